// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } irq_state_e;

    localparam logic [7:0]  AddrPend  = 8'h3C;
    localparam logic [7:0]  AddrMask  = 8'h3D;
    localparam logic [7:0]  AddrStat  = 8'h3E;
    localparam int unsigned VecStride = 2;

    // Bits at or above the source count never hold state.
    function automatic logic [7:0] src_mask(input int unsigned n);
        logic [7:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: source 0 has the highest priority.
module irq_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [2:0]   idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-captured pending flags, enable mask, fixed-priority
// arbitration and a request/ack/reti handshake with the core.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  VEC_BASE  = 8'h02,
    parameter logic [7:0]  ADDR_PEND = AddrPend,
    parameter logic [7:0]  ADDR_MASK = AddrMask,
    parameter logic [7:0]  ADDR_STAT = AddrStat
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [7:0]       addr,
    input  logic [7:0]       wdata,
    input  logic             write,
    input  logic             read,
    output logic [7:0]       rdata,
    input  logic             gie,
    output logic             irq_req,
    output logic [7:0]       irq_vec,
    input  logic             irq_ack,
    input  logic             reti,
    output logic             in_service
);

    localparam logic [7:0] SrcMask = src_mask(N_SRC);

    irq_state_e state_q, state_d;
    logic [7:0] irq_q, irq_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] vec_q, vec_d;
    logic [2:0] sel_q, sel_d;

    logic [7:0] irq_ext, set_v, clr_v, elig;
    logic [2:0] win_idx;
    logic       win_valid;
    logic       ack_ok;

    always_comb begin
        irq_ext              = '0;
        irq_ext[N_SRC-1:0]   = irq_in;
    end

    assign elig = pend_q & mask_q;

    irq_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .req_i   (elig[N_SRC-1:0]),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            irq_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            vec_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            vec_q   <= vec_d;
            sel_q   <= sel_d;
        end
    end

    // Selection and vector are latched on entry to StReq and never re-arbitrated there.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        case (state_q)
            StIdle: begin
                if (gie && win_valid) begin
                    state_d = StReq;
                    sel_d   = win_idx;
                    vec_d   = VEC_BASE + 8'(VecStride) * {5'b0, win_idx};
                end
            end
            StReq: begin
                if (irq_ack) begin
                    state_d = StService;
                end else if (!elig[sel_q] || !gie) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (reti) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq_req    = (state_q == StReq);
        in_service = (state_q == StService);
        irq_vec    = vec_q;
        rdata      = rdata_q;
        ack_ok     = (state_q == StReq) && irq_ack;
    end

    // A same-cycle rising edge beats a clear; reads see pre-write values.
    always_comb begin
        irq_d  = irq_ext;
        set_v  = irq_ext & ~irq_q;
        clr_v  = '0;
        if (write && (addr == ADDR_PEND)) clr_v = wdata;
        if (ack_ok) clr_v = clr_v | (8'(1) << sel_q);
        pend_d = ((pend_q & ~clr_v) | set_v) & SrcMask;

        mask_d = mask_q;
        if (write && (addr == ADDR_MASK)) mask_d = wdata & SrcMask;

        rdata_d = rdata_q;
        if (read) begin
            if (addr == ADDR_PEND) begin
                rdata_d = pend_q;
            end else if (addr == ADDR_MASK) begin
                rdata_d = mask_q;
            end else if (addr == ADDR_STAT) begin
                rdata_d = {state_q, 3'b000, sel_q};
            end else begin
                rdata_d = 8'h00;
            end
        end
    end

endmodule
